mdu_arbiter: RTL and testbench

- Shares one multiply/divide unit (mdu_top, 32-bit, RISC-V M-extension funct3 op encoding) between NREQ independent requesters, e.g. two issue ports or two harts.
- Arbitrates round-robin, latches the winner's operands, and drives the MDU valid/ready handshake with the spacing the MDU needs between operations.
- Returns each result to its owning requester through a held response register.
- Sits between the requesters and mdu_top; mdu_top is instantiated beside it, not inside it.

---
 rtl/mdu_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/mdu_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_mdu_arbiter.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// ============================================================================
// Module  : mdu_pkg
// Brief   : Shared constants for the MDU arbiter: funct3 op codes, FSM states.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_BUSY  = 2'd1;
    localparam logic [STATE_W-1:0] ST_DRAIN = 2'd2;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin grant; search starts just above 'last'.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter  int N  = 2,
    localparam int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    input  logic          enable,
    output logic [N-1:0]  gnt
);

    localparam logic [LW:0] NV = (LW+1)'(N);

    logic [LW:0]   sum;
    logic [LW-1:0] idx;
    logic          found;

    // One extra bit on the sum keeps last+i from overflowing before the wrap.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            sum = {1'b0, last} + (LW+1)'(i);
            if (sum >= NV) begin
                sum = sum - NV;
            end
            idx = sum[LW-1:0];
            if (enable && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mdu_arbiter.sv
// ============================================================================
// Module  : mdu_arbiter
// Brief   : Round-robin sharing of one multiply/divide unit between NREQ
//           requesters, with held per-owner responses and post-op spacing.
//           Optional performance counters under `MDU_ARB_PERF_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_arbiter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2,
    parameter int GAP   = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NREQ-1:0]       i_req_valid,
    output logic [NREQ-1:0]       o_req_ready,
    input  logic [NREQ*WIDTH-1:0] i_req_rs1,
    input  logic [NREQ*WIDTH-1:0] i_req_rs2,
    input  logic [NREQ*3-1:0]     i_req_op,
    output logic [NREQ-1:0]       o_rsp_valid,
    input  logic [NREQ-1:0]       i_rsp_ready,
    output logic [WIDTH-1:0]      o_rsp_rd,
    output logic                  o_mdu_valid,
    output logic [WIDTH-1:0]      o_mdu_rs1,
    output logic [WIDTH-1:0]      o_mdu_rs2,
    output logic [2:0]            o_mdu_op,
    input  logic                  i_mdu_ready,
    input  logic [WIDTH-1:0]      i_mdu_rd
`ifdef MDU_ARB_PERF_EN
    ,
    output logic [NREQ*32-1:0]    o_perf_grants,
    output logic [31:0]           o_perf_busy,
    output logic [31:0]           o_perf_stall
`endif
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int GW = $clog2(GAP + 1);
    localparam logic [GW-1:0] GAP_LD = GW'(GAP);

    logic [STATE_W-1:0] state_q, state_d;
    logic [LW-1:0]      last_q, last_d;
    logic [LW-1:0]      owner_q, owner_d;
    logic               mdu_valid_q, mdu_valid_d;
    logic [WIDTH-1:0]   mdu_rs1_q, mdu_rs1_d;
    logic [WIDTH-1:0]   mdu_rs2_q, mdu_rs2_d;
    logic [2:0]         mdu_op_q, mdu_op_d;
    logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_rd_q, rsp_rd_d;
    logic [GW-1:0]      gap_q, gap_d;

    logic [NREQ-1:0]    w_gnt;
    logic               w_arb_en;
    logic               w_xfer;
    logic [LW-1:0]      w_gnt_idx;
    logic [WIDTH-1:0]   w_sel_rs1;
    logic [WIDTH-1:0]   w_sel_rs2;
    logic [2:0]         w_sel_op;

    // Reset also gates the grant so no ready is shown while reset is held.
    assign w_arb_en = (state_q == ST_IDLE) && i_rst_n;

    rr_arbiter #(.N(NREQ)) u_rr (
        .req    (i_req_valid),
        .last   (last_q),
        .enable (w_arb_en),
        .gnt    (w_gnt)
    );

    assign w_xfer = |w_gnt;

    always_comb begin
        w_gnt_idx = '0;
        w_sel_rs1 = '0;
        w_sel_rs2 = '0;
        w_sel_op  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_gnt[k]) begin
                w_gnt_idx = LW'(k);
                w_sel_rs1 = i_req_rs1[k*WIDTH +: WIDTH];
                w_sel_rs2 = i_req_rs2[k*WIDTH +: WIDTH];
                w_sel_op  = i_req_op[k*3 +: 3];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DRAIN exits on the post-update counter and response so both may finish together.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (w_xfer)      state_d = ST_BUSY;
            ST_BUSY:  if (i_mdu_ready) state_d = ST_DRAIN;
            ST_DRAIN: if ((gap_d == '0) && (rsp_valid_d == '0)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        last_d      = last_q;
        owner_d     = owner_q;
        mdu_valid_d = mdu_valid_q;
        mdu_rs1_d   = mdu_rs1_q;
        mdu_rs2_d   = mdu_rs2_q;
        mdu_op_d    = mdu_op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rd_d    = rsp_rd_q;
        gap_d       = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (w_xfer) begin
                    mdu_rs1_d   = w_sel_rs1;
                    mdu_rs2_d   = w_sel_rs2;
                    mdu_op_d    = w_sel_op;
                    owner_d     = w_gnt_idx;
                    last_d      = w_gnt_idx;
                    mdu_valid_d = 1'b1;
                end
            end
            ST_BUSY: begin
                if (i_mdu_ready) begin
                    rsp_rd_d             = i_mdu_rd;
                    rsp_valid_d          = '0;
                    rsp_valid_d[owner_q] = 1'b1;
                    mdu_valid_d          = 1'b0;
                    gap_d                = GAP_LD;
                end
            end
            ST_DRAIN: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GW'(1);
                end
                rsp_valid_d = rsp_valid_q & ~i_rsp_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_q      <= '0;
            owner_q     <= '0;
            mdu_valid_q <= 1'b0;
            mdu_rs1_q   <= '0;
            mdu_rs2_q   <= '0;
            mdu_op_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rd_q    <= '0;
            gap_q       <= '0;
        end else begin
            last_q      <= last_d;
            owner_q     <= owner_d;
            mdu_valid_q <= mdu_valid_d;
            mdu_rs1_q   <= mdu_rs1_d;
            mdu_rs2_q   <= mdu_rs2_d;
            mdu_op_q    <= mdu_op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rd_q    <= rsp_rd_d;
            gap_q       <= gap_d;
        end
    end

    assign o_req_ready = w_gnt;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rd    = rsp_rd_q;
    assign o_mdu_valid = mdu_valid_q;
    assign o_mdu_rs1   = mdu_rs1_q;
    assign o_mdu_rs2   = mdu_rs2_q;
    assign o_mdu_op    = mdu_op_q;

`ifdef MDU_ARB_PERF_EN
    logic [31:0] grants_q [NREQ];
    logic [31:0] grants_d [NREQ];
    logic [31:0] busy_q, busy_d;
    logic [31:0] stall_q, stall_d;
    logic        w_stall;

    assign w_stall = ((state_q == ST_IDLE) || (state_q == ST_DRAIN)) &&
                     (|i_req_valid) && !(|w_gnt);

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            grants_d[k] = grants_q[k] + (w_gnt[k] ? 32'd1 : 32'd0);
        end
        busy_d  = busy_q + ((state_q == ST_BUSY) ? 32'd1 : 32'd0);
        stall_d = stall_q + (w_stall ? 32'd1 : 32'd0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NREQ; k++) begin
                grants_q[k] <= '0;
            end
            busy_q  <= '0;
            stall_q <= '0;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                grants_q[k] <= grants_d[k];
            end
            busy_q  <= busy_d;
            stall_q <= stall_d;
        end
    end

    for (genvar k = 0; k < NREQ; k++) begin : g_perf_pack
        assign o_perf_grants[k*32 +: 32] = grants_q[k];
    end

    assign o_perf_busy  = busy_q;
    assign o_perf_stall = stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mdu_arbiter.sv
// ============================================================================
// Module  : tb_mdu_arbiter
// Brief   : Scoreboard bench for mdu_arbiter with a behavioural MDU beside it.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_arbiter;
    import mdu_pkg::*;

    localparam int WIDTH   = 32;
    localparam int NREQ    = 2;
    localparam int GAP     = 2;
    localparam int MDU_LAT = 4;

    logic                  clk = 1'b0;
    logic                  i_rst_n;
    logic [NREQ-1:0]       i_req_valid;
    logic [NREQ-1:0]       o_req_ready;
    logic [NREQ*WIDTH-1:0] i_req_rs1;
    logic [NREQ*WIDTH-1:0] i_req_rs2;
    logic [NREQ*3-1:0]     i_req_op;
    logic [NREQ-1:0]       o_rsp_valid;
    logic [NREQ-1:0]       i_rsp_ready;
    logic [WIDTH-1:0]      o_rsp_rd;
    logic                  o_mdu_valid;
    logic [WIDTH-1:0]      o_mdu_rs1;
    logic [WIDTH-1:0]      o_mdu_rs2;
    logic [2:0]            o_mdu_op;
    logic                  i_mdu_ready;
    logic [WIDTH-1:0]      i_mdu_rd;
`ifdef MDU_ARB_PERF_EN
    logic [NREQ*32-1:0]    o_perf_grants;
    logic [31:0]           o_perf_busy;
    logic [31:0]           o_perf_stall;
`endif

    always #5 clk = ~clk;

    mdu_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .GAP(GAP)) dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_rs1   (i_req_rs1),
        .i_req_rs2   (i_req_rs2),
        .i_req_op    (i_req_op),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_rd    (o_rsp_rd),
        .o_mdu_valid (o_mdu_valid),
        .o_mdu_rs1   (o_mdu_rs1),
        .o_mdu_rs2   (o_mdu_rs2),
        .o_mdu_op    (o_mdu_op),
        .i_mdu_ready (i_mdu_ready),
        .i_mdu_rd    (i_mdu_rd)
`ifdef MDU_ARB_PERF_EN
        ,
        .o_perf_grants (o_perf_grants),
        .o_perf_busy   (o_perf_busy),
        .o_perf_stall  (o_perf_stall)
`endif
    );

    typedef struct {
        int          req;
        logic [31:0] rd;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks    = 0;
    int   n_fail      = 0;
    int   n_rsp       = 0;
    int   cyc         = 0;
    int   last_comp   = -1;
    int   busy_cycles = 0;
    bit   inject_stale = 1'b0;
    logic prev_valid  = 1'b0;

    function automatic logic [31:0] mdu_calc(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        logic [63:0] p;
        logic        ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            MULH:   begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
            MULHSU: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return p[63:32]; end
            MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            DIV:    return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'($signed(a) / $signed(b)));
            DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            REM:    return (b == 0) ? a : (ovf ? 32'h0 : 32'($signed(a) % $signed(b)));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Behavioural MDU: completes MDU_LAT cycles after valid; can emit stray strobes.
    initial begin
        int cnt;
        cnt         = 0;
        i_mdu_ready = 1'b0;
        i_mdu_rd    = '0;
        forever begin
            @(negedge clk);
            i_mdu_ready = 1'b0;
            if (!i_rst_n) begin
                cnt = 0;
            end else if (o_mdu_valid) begin
                cnt++;
                if (cnt >= MDU_LAT) begin
                    i_mdu_ready = 1'b1;
                    i_mdu_rd    = mdu_calc(o_mdu_op, o_mdu_rs1, o_mdu_rs2);
                    cnt         = 0;
                end
            end else begin
                cnt = 0;
                if (inject_stale) begin
                    i_mdu_ready = 1'b1;
                    i_mdu_rd    = 32'hDEAD_BEEF;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (i_rst_n && ((o_rsp_valid & i_rsp_ready) != '0)) begin
            n_checks++;
            n_rsp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got valid=%b rd=%h, required no response", o_rsp_valid, o_rsp_rd);
            end else begin
                mon_e = sb.pop_front();
                if (o_rsp_valid !== (2'b01 << mon_e.req) || o_rsp_rd !== mon_e.rd) begin
                    n_fail++;
                    $display("FAIL rsp_data: got valid=%b rd=%h, required valid=%b rd=%h",
                             o_rsp_valid, o_rsp_rd, 2'b01 << mon_e.req, mon_e.rd);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        if (!i_rst_n) begin
            last_comp   = -1;
            prev_valid  = 1'b0;
            busy_cycles = 0;
        end else begin
            if (o_mdu_valid) busy_cycles++;
            if (i_mdu_ready && prev_valid && !o_mdu_valid) last_comp = cyc;
            if (o_mdu_valid && !prev_valid && last_comp >= 0) begin
                n_checks++;
                if (cyc - last_comp < GAP + 1) begin
                    n_fail++;
                    $display("FAIL issue_gap: got %0d cycles, required >= %0d", cyc - last_comp, GAP + 1);
                end
            end
            prev_valid = o_mdu_valid;
        end
    end

    task automatic issue(int k, logic [31:0] a, logic [31:0] b, logic [2:0] op, logic [31:0] exp_rd);
        bit acc = 1'b0;
        i_req_rs1[k*32 +: 32] = a;
        i_req_rs2[k*32 +: 32] = b;
        i_req_op[k*3 +: 3]    = op;
        i_req_valid[k]        = 1'b1;
        sb.push_back('{k, exp_rd});
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = o_req_ready[k];
            @(posedge clk);
            #1;
        end
        i_req_valid[k] = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: got no ready for req%0d, required acceptance", k);
        end
    endtask

    task automatic wait_drain(string name);
        bit done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(posedge clk);
            #1;
            done = (sb.size() == 0) && (o_rsp_valid == '0) && !o_mdu_valid;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_drain: got %0d pending results, required 0", name, sb.size());
        end
        repeat (GAP + 2) @(posedge clk);
        #1;
    endtask

    task automatic drive_both(logic [31:0] a0, logic [31:0] b0, logic [2:0] op0,
                              logic [31:0] a1, logic [31:0] b1, logic [2:0] op1,
                              int n0, int n1, logic [1:0] first);
        int         rem [2];
        int         k;
        logic [1:0] expg;
        rem[0] = n0;
        rem[1] = n1;
        expg   = first;
        i_req_rs1   = {a1, a0};
        i_req_rs2   = {b1, b0};
        i_req_op    = {op1, op0};
        i_req_valid = 2'b11;
        for (int t = 0; t < 400 && (rem[0] + rem[1]) > 0; t++) begin
            @(negedge clk);
            k = -1;
            if (o_req_ready != '0) begin
                n_checks++;
                if (o_req_ready !== expg) begin
                    n_fail++;
                    $display("FAIL grant_order: got %b, required %b", o_req_ready, expg);
                end
                k = o_req_ready[1] ? 1 : 0;
            end
            @(posedge clk);
            #1;
            if (k >= 0) begin
                rem[k]--;
                if (rem[k] == 0) i_req_valid[k] = 1'b0;
                expg = (rem[1-k] > 0) ? (2'b01 << (1 - k)) : (2'b01 << k);
            end
        end
        i_req_valid = '0;
        if ((rem[0] + rem[1]) > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drive_both_timeout: got %0d grants outstanding, required 0", rem[0] + rem[1]);
        end
    endtask

    task automatic test_reset;
        i_rst_n     = 1'b0;
        i_req_valid = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks += 4;
        if (o_req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b, required 00", o_req_ready); end
        if (o_rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b, required 00", o_rsp_valid); end
        if (o_mdu_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_mdu_valid: got %b, required 0", o_mdu_valid); end
        if ({o_mdu_rs1, o_mdu_rs2, o_mdu_op, o_rsp_rd} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got rs1=%h rs2=%h op=%b rd=%h, required all 0", o_mdu_rs1, o_mdu_rs2, o_mdu_op, o_rsp_rd);
        end
        i_req_valid = 2'b00;
        i_rst_n     = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single;
        issue(0, 32'd3, 32'hFFFF_FFFE, MUL, 32'hFFFF_FFFA);
        n_checks += 2;
        if (o_mdu_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mdu_valid_latency: got %b one cycle after accept, required 1", o_mdu_valid);
        end
        if (o_mdu_rs1 !== 32'd3 || o_mdu_rs2 !== 32'hFFFF_FFFE || o_mdu_op !== MUL) begin
            n_fail++;
            $display("FAIL mdu_operands: got %h %h %b, required 00000003 fffffffe 000", o_mdu_rs1, o_mdu_rs2, o_mdu_op);
        end
        wait_drain("single");
    endtask

    task automatic test_req1;
        issue(1, 32'h8000_0000, 32'd2, MULH, 32'hFFFF_FFFF);
        wait_drain("req1");
    endtask

    task automatic test_alternate;
        sb.push_back('{0, 32'd14});
        sb.push_back('{1, 32'd2});
        sb.push_back('{0, 32'd14});
        sb.push_back('{1, 32'd2});
        drive_both(32'd100, 32'd7, DIVU, 32'd100, 32'd7, REMU, 2, 2, 2'b01);
        wait_drain("alternate");
    endtask

    task automatic test_backpressure;
        bit seen = 1'b0;
        i_rsp_ready = 2'b10;
        issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULHU, 32'hFFFF_FFFE);
        i_req_rs1[63:32] = 32'd9;
        i_req_rs2[63:32] = 32'd9;
        i_req_op[5:3]    = MUL;
        i_req_valid[1]   = 1'b1;
        sb.push_back('{1, 32'd81});
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            seen = o_rsp_valid[0];
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL stall_rsp_timeout: got no response, required rsp_valid[0]");
        end
        for (int t = 0; t < 10; t++) begin
            if (t > 0) @(negedge clk);
            n_checks++;
            if (o_rsp_valid !== 2'b01 || o_rsp_rd !== 32'hFFFF_FFFE || o_req_ready !== 2'b00) begin
                n_fail++;
                $display("FAIL stall_hold: got rsp_valid=%b rd=%h req_ready=%b, required 01 fffffffe 00",
                         o_rsp_valid, o_rsp_rd, o_req_ready);
            end
        end
        @(posedge clk);
        #1;
        i_rsp_ready = 2'b11;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (o_req_ready !== 2'b10) begin
            n_fail++;
            $display("FAIL stall_resume: got req_ready=%b, required 10", o_req_ready);
        end
        @(posedge clk);
        #1;
        i_req_valid[1] = 1'b0;
        wait_drain("backpressure");
    endtask

    task automatic test_back_to_back;
        int start;
        start        = n_rsp;
        inject_stale = 1'b1;
        issue(0, 32'd5, 32'd6, MUL, 32'd30);
        issue(0, 32'd7, 32'd8, MUL, 32'd56);
        wait_drain("back_to_back");
        repeat (6) @(posedge clk);
        #1;
        inject_stale = 1'b0;
        n_checks++;
        if (n_rsp - start !== 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d responses, required 2", n_rsp - start);
        end
    endtask

    task automatic test_reset_mid;
        issue(0, 32'd100, 32'hFFFF_FFF9, DIV, 32'hFFFF_FFF2);
        @(posedge clk);
        n_checks++;
        if (o_mdu_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy: got mdu_valid=%b before reset, required 1", o_mdu_valid);
        end
        #3;
        i_rst_n = 1'b0;
        #1;
        n_checks += 2;
        if (o_mdu_valid !== 1'b0 || o_req_ready !== 2'b00 || o_rsp_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_reset_ctrl: got mdu_valid=%b req_ready=%b rsp_valid=%b, required 0 00 00",
                     o_mdu_valid, o_req_ready, o_rsp_valid);
        end
        if ({o_mdu_rs1, o_mdu_rs2, o_mdu_op, o_rsp_rd} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_data: got rs1=%h rs2=%h op=%b rd=%h, required all 0", o_mdu_rs1, o_mdu_rs2, o_mdu_op, o_rsp_rd);
        end
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        i_rst_n = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{1, 32'd2});
        sb.push_back('{0, 32'hFFFF_FFF2});
        drive_both(32'd100, 32'hFFFF_FFF9, DIV, 32'd100, 32'hFFFF_FFF9, REM, 1, 1, 2'b10);
        wait_drain("reset_mid");
    endtask

`ifdef MDU_ARB_PERF_EN
    task automatic test_perf;
        @(negedge clk);
        i_rst_n = 1'b0;
        @(negedge clk);
        i_rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(0, 32'd2, 32'd3, MUL, 32'd6);     wait_drain("perf");
        issue(1, 32'd20, 32'd4, DIVU, 32'd5);   wait_drain("perf");
        issue(0, 32'd17, 32'd5, REMU, 32'd2);   wait_drain("perf");
        issue(1, 32'd0, 32'd0, DIVU, 32'hFFFF_FFFF); wait_drain("perf");
        issue(0, 32'd4, 32'd4, MUL, 32'd16);    wait_drain("perf");
        n_checks += 3;
        if (o_perf_grants[31:0] !== 32'd3) begin n_fail++; $display("FAIL perf_grants0: got %0d, required 3", o_perf_grants[31:0]); end
        if (o_perf_grants[63:32] !== 32'd2) begin n_fail++; $display("FAIL perf_grants1: got %0d, required 2", o_perf_grants[63:32]); end
        if (o_perf_busy !== 32'(busy_cycles)) begin n_fail++; $display("FAIL perf_busy: got %0d, required %0d", o_perf_busy, busy_cycles); end
    endtask
`endif

    initial begin
        i_rst_n     = 1'b0;
        i_req_valid = '0;
        i_req_rs1   = '0;
        i_req_rs2   = '0;
        i_req_op    = '0;
        i_rsp_ready = 2'b11;
        test_reset();
        test_single();
        test_req1();
        test_alternate();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef MDU_ARB_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
